// File: rtl/axi_10g_ethernet_0_arp_tx_if.sv
// Command and AXI4-Stream signals of the ARP transmitter.
// The master modport is the transmitter: it sinks commands and drives the stream.
// The slave modport is the environment around it: command source and stream sink.
interface axi_10g_ethernet_0_arp_tx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [47:0] cmd_mac;
  logic [31:0] cmd_ip;
  logic [63:0] tx_axis_tdata;
  logic [7:0]  tx_axis_tkeep;
  logic        tx_axis_tvalid;
  logic        tx_axis_tlast;
  logic        tx_axis_tready;

  modport master (
    input  cmd_valid, cmd_op, cmd_mac, cmd_ip, tx_axis_tready,
    output cmd_ready, tx_axis_tdata, tx_axis_tkeep, tx_axis_tvalid, tx_axis_tlast
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_mac, cmd_ip, tx_axis_tready,
    input  cmd_ready, tx_axis_tdata, tx_axis_tkeep, tx_axis_tvalid, tx_axis_tlast
  );
endinterface

// File: rtl/axi_10g_ethernet_0_arp_tx.sv
// ARP reply/request frame transmitter for the 10G MAC TX path.
// Commands are queued in a small FIFO. A two-state generator walks the eight
// 64-bit beats of a 60-byte ARP frame into a registered AXI4-Stream output
// stage. That stage loads whenever it is empty or being drained, so frames
// stream back to back and no output depends combinationally on tready.
module axi_10g_ethernet_0_arp_tx #(
  parameter int CMD_FIFO_DEPTH = 4
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [47:0]                       local_mac,
  input  logic [31:0]                       local_ip,
  axi_10g_ethernet_0_arp_tx_if.master       bus,
  output logic                              busy,
  output logic [15:0]                       frames_sent
);

  localparam int AW    = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int CMD_W = 81;

  typedef enum logic {IDLE, SEND} state_t;

  // Builds the whole 60-byte frame, byte n at [8n+7:8n], fields MSB first.
  function automatic logic [511:0] build_frame(
    input logic        op,
    input logic [47:0] pmac,
    input logic [31:0] pip,
    input logic [47:0] lmac,
    input logic [31:0] lip
  );
    logic [511:0] f;
    f = '0;
    for (int k = 0; k < 6; k++) begin
      f[8*k +: 8]      = op ? 8'hFF : pmac[47-8*k -: 8];
      f[8*(6+k) +: 8]  = lmac[47-8*k -: 8];
      f[8*(22+k) +: 8] = lmac[47-8*k -: 8];
      f[8*(32+k) +: 8] = op ? 8'h00 : pmac[47-8*k -: 8];
    end
    for (int k = 0; k < 4; k++) begin
      f[8*(28+k) +: 8] = lip[31-8*k -: 8];
      f[8*(38+k) +: 8] = pip[31-8*k -: 8];
    end
    f[8*12 +: 8] = 8'h08;
    f[8*13 +: 8] = 8'h06;
    f[8*14 +: 8] = 8'h00;
    f[8*15 +: 8] = 8'h01;
    f[8*16 +: 8] = 8'h08;
    f[8*17 +: 8] = 8'h00;
    f[8*18 +: 8] = 8'h06;
    f[8*19 +: 8] = 8'h04;
    f[8*20 +: 8] = 8'h00;
    f[8*21 +: 8] = op ? 8'h01 : 8'h02;
    return f;
  endfunction

  logic [CMD_W-1:0] mem [CMD_FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, push, pop, load, out_ready;
  logic [CMD_W-1:0] head;

  state_t           state_q, state_d;
  logic [2:0]       beat_q, beat_d;

  logic             cur_op;
  logic [47:0]      cur_mac, cur_lmac;
  logic [31:0]      cur_ip, cur_lip;
  logic [511:0]     frame;
  logic [63:0]      beat_data;

  // ---- command queue ----
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.cmd_ready = !full && !areset;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem[rd_ptr[AW-1:0]];

  // Queue storage; contents need no reset since the pointers define validity.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.cmd_op, bus.cmd_mac, bus.cmd_ip};
  end

  // Queue pointers; reset flushes any pending commands.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // ---- frame generator ----
  // Popped command and local addresses are frozen for the whole frame.
  always_ff @(posedge aclk) begin
    if (pop) begin
      cur_op   <= head[80];
      cur_mac  <= head[79:32];
      cur_ip   <= head[31:0];
      cur_lmac <= local_mac;
      cur_lip  <= local_ip;
    end
  end

  assign frame     = build_frame(cur_op, cur_mac, cur_ip, cur_lmac, cur_lip);
  assign beat_data = frame[{beat_q, 6'd0} +: 64];
  assign out_ready = !bus.tx_axis_tvalid || bus.tx_axis_tready;

  // Generator state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      beat_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next state: pop when idle, feed beats into the output stage, chain frames.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          beat_d  = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          load = 1'b1;
          if (beat_q == 3'd7) begin
            beat_d = 3'd0;
            if (!empty) pop = 1'b1;
            else        state_d = IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- output stage ----
  // Registered stream outputs: hold while stalled, reload or drain on handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bus.tx_axis_tvalid <= 1'b0;
      bus.tx_axis_tdata  <= '0;
      bus.tx_axis_tkeep  <= '0;
      bus.tx_axis_tlast  <= 1'b0;
    end else if (load) begin
      bus.tx_axis_tvalid <= 1'b1;
      bus.tx_axis_tdata  <= beat_data;
      bus.tx_axis_tkeep  <= (beat_q == 3'd7) ? 8'h0F : 8'hFF;
      bus.tx_axis_tlast  <= (beat_q == 3'd7);
    end else if (bus.tx_axis_tready) begin
      bus.tx_axis_tvalid <= 1'b0;
      bus.tx_axis_tlast  <= 1'b0;
    end
  end

  // Completed-frame counter, bumped on the last-beat handshake; wraps naturally.
  always_ff @(posedge aclk) begin
    if (areset) begin
      frames_sent <= 16'd0;
    end else if (bus.tx_axis_tvalid && bus.tx_axis_tready && bus.tx_axis_tlast) begin
      frames_sent <= frames_sent + 16'd1;
    end
  end

  assign busy = (state_q != IDLE) || !empty || bus.tx_axis_tvalid;

endmodule

// File: tb/tb_axi_10g_ethernet_0_arp_tx.sv
// Directed bench for the ARP transmitter: reset state, reply/request frames
// against hand-computed beats, random backpressure, queued burst, mid-frame
// reset and a runtime local MAC change.
module tb_axi_10g_ethernet_0_arp_tx;
  logic        aclk = 1'b0;
  logic        areset;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic        busy;
  logic [15:0] frames_sent;

  axi_10g_ethernet_0_arp_tx_if bus ();

  axi_10g_ethernet_0_arp_tx #(.CMD_FIFO_DEPTH(4)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .local_mac   (local_mac),
    .local_ip    (local_ip),
    .bus         (bus),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 aclk = ~aclk;

  int          n_err = 0;
  int          n_chk = 0;
  logic [63:0] exp_f [8];
  logic [63:0] exp_reply [8];
  logic [63:0] exp_req [8];
  int          idle_cnt;
  bit          mac_chg_en = 1'b0;
  logic [47:0] mac_chg_val;

  localparam logic [47:0] LMAC  = 48'h0200_C0A8_0A0A;
  localparam logic [31:0] LIP   = 32'hC0A8_0214;
  localparam logic [47:0] PMAC  = 48'h0011_2233_4455;
  localparam logic [31:0] PIP   = 32'hC0A8_0201;
  localparam logic [47:0] LMAC2 = 48'h0200_DEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected beat of a frame, assembled by appending fields in wire order.
  function automatic logic [63:0] model_beat(input logic op, input logic [47:0] pm,
                                             input logic [31:0] pi, input logic [47:0] lm,
                                             input logic [31:0] li, input int beat);
    logic [7:0]  f [64];
    logic [47:0] dst, tgt;
    logic [79:0] hdr;
    logic [63:0] r;
    int          n;
    for (int i = 0; i < 64; i++) f[i] = 8'h00;
    dst = op ? 48'hFFFF_FFFF_FFFF : pm;
    tgt = op ? 48'h0 : pm;
    hdr = {32'h0806_0001, 32'h0800_0604, 8'h00, (op ? 8'h01 : 8'h02)};
    n = 0;
    for (int k = 0; k < 6; k++)  begin f[n] = dst[47-8*k -: 8]; n++; end
    for (int k = 0; k < 6; k++)  begin f[n] = lm[47-8*k -: 8];  n++; end
    for (int k = 0; k < 10; k++) begin f[n] = hdr[79-8*k -: 8]; n++; end
    for (int k = 0; k < 6; k++)  begin f[n] = lm[47-8*k -: 8];  n++; end
    for (int k = 0; k < 4; k++)  begin f[n] = li[31-8*k -: 8];  n++; end
    for (int k = 0; k < 6; k++)  begin f[n] = tgt[47-8*k -: 8]; n++; end
    for (int k = 0; k < 4; k++)  begin f[n] = pi[31-8*k -: 8];  n++; end
    for (int j = 0; j < 8; j++) r[8*j +: 8] = f[8*beat + j];
    return r;
  endfunction

  task automatic set_model(input logic op, input logic [47:0] pm, input logic [31:0] pi,
                           input logic [47:0] lm, input logic [31:0] li);
    for (int b = 0; b < 8; b++) exp_f[b] = model_beat(op, pm, pi, lm, li, b);
  endtask

  task automatic push_cmd(input logic op, input logic [47:0] m, input logic [31:0] ip);
    bit ok;
    ok = 1'b0;
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mac   = m;
    bus.cmd_ip    = ip;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("push_timeout", 64'(ok), 64'd1);
    @(posedge aclk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Receives one frame against exp_f; rnd randomises tready and checks stall stability.
  task automatic recv_frame(input string tag, input bit rnd);
    int          b;
    bit          stalled;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    b = 0; stalled = 1'b0; idle_cnt = 0;
    for (int cyc = 0; cyc < 300 && b < 8; cyc++) begin
      @(posedge aclk); #1;
      bus.tx_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (stalled) begin
        chk({tag, "_hold_vld"},  64'(bus.tx_axis_tvalid), 64'd1);
        chk({tag, "_hold_data"}, bus.tx_axis_tdata, sd);
        chk({tag, "_hold_keep"}, 64'(bus.tx_axis_tkeep), 64'(sk));
        chk({tag, "_hold_last"}, 64'(bus.tx_axis_tlast), 64'(sl));
      end
      stalled = 1'b0;
      if (!bus.tx_axis_tvalid) begin
        idle_cnt++;
      end else if (bus.tx_axis_tready) begin
        chk($sformatf("%s_b%0d_data", tag, b), bus.tx_axis_tdata, exp_f[b]);
        chk($sformatf("%s_b%0d_keep", tag, b), 64'(bus.tx_axis_tkeep), (b == 7) ? 64'h0F : 64'hFF);
        chk($sformatf("%s_b%0d_last", tag, b), 64'(bus.tx_axis_tlast), (b == 7) ? 64'd1 : 64'd0);
        b++;
        if (mac_chg_en && b == 3) begin
          local_mac  = mac_chg_val;
          mac_chg_en = 1'b0;
        end
      end else begin
        stalled = 1'b1;
        sd = bus.tx_axis_tdata;
        sk = bus.tx_axis_tkeep;
        sl = bus.tx_axis_tlast;
      end
    end
    if (b != 8) chk({tag, "_beats_timeout"}, 64'(b), 64'd8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_reply = '{64'h0002_5544_3322_1100, 64'h0100_0608_0A0A_A8C0,
                  64'h0002_0200_0406_0008, 64'h1402_A8C0_0A0A_A8C0,
                  64'hA8C0_5544_3322_1100, 64'h0000_0000_0000_0102,
                  64'h0, 64'h0};
    exp_req   = '{64'h0002_FFFF_FFFF_FFFF, 64'h0100_0608_0A0A_A8C0,
                  64'h0002_0100_0406_0008, 64'h1402_A8C0_0A0A_A8C0,
                  64'hA8C0_0000_0000_0000, 64'h0000_0000_0000_0102,
                  64'h0, 64'h0};

    areset             = 1'b1;
    local_mac          = LMAC;
    local_ip           = LIP;
    bus.cmd_valid      = 1'b0;
    bus.cmd_op         = 1'b0;
    bus.cmd_mac        = '0;
    bus.cmd_ip         = '0;
    bus.tx_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 64'(bus.tx_axis_tvalid), 64'd0);
    chk("rst_tdata",  bus.tx_axis_tdata, 64'd0);
    chk("rst_tkeep",  64'(bus.tx_axis_tkeep), 64'd0);
    chk("rst_tlast",  64'(bus.tx_axis_tlast), 64'd0);
    chk("rst_frames", 64'(frames_sent), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Reset during beat 3 of a reply frame.
    bus.tx_axis_tready = 1'b1;
    push_cmd(1'b0, PMAC, PIP);
    repeat (5) @(posedge aclk);
    #1;
    chk("midrst_beat3", bus.tx_axis_tdata, exp_reply[3]);
    areset = 1'b1;
    @(negedge aclk);
    chk("midrst_cmd_ready_in", 64'(bus.cmd_ready), 64'd0);
    @(posedge aclk); #1;
    chk("midrst_tvalid", 64'(bus.tx_axis_tvalid), 64'd0);
    chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("midrst_after_ready", 64'(bus.cmd_ready), 64'd1);
    chk("midrst_after_busy",  64'(busy), 64'd0);
    chk("midrst_after_frames", 64'(frames_sent), 64'd0);
    chk("midrst_after_tvalid", 64'(bus.tx_axis_tvalid), 64'd0);

    // Reply frame with latency and exact beat count.
    push_cmd(1'b0, PMAC, PIP);
    @(negedge aclk);
    chk("lat_t0", 64'(bus.tx_axis_tvalid), 64'd0);
    @(negedge aclk);
    chk("lat_t1", 64'(bus.tx_axis_tvalid), 64'd0);
    exp_f = exp_reply;
    recv_frame("reply", 1'b0);
    chk("reply_idle", 64'(idle_cnt), 64'd0);
    @(negedge aclk);
    chk("reply_tvalid_drop", 64'(bus.tx_axis_tvalid), 64'd0);
    chk("reply_frames", 64'(frames_sent), 64'd1);
    chk("reply_busy", 64'(busy), 64'd0);

    // Request frame.
    push_cmd(1'b1, PMAC, PIP);
    exp_f = exp_req;
    recv_frame("request", 1'b0);
    @(negedge aclk);
    chk("request_frames", 64'(frames_sent), 64'd2);

    // Random backpressure must not change the byte stream.
    push_cmd(1'b0, PMAC, PIP);
    exp_f = exp_reply;
    recv_frame("bp", 1'b1);
    bus.tx_axis_tready = 1'b1;
    @(negedge aclk);
    chk("bp_frames", 64'(frames_sent), 64'd3);

    // Burst of five commands while the stream is stalled.
    bus.tx_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(1'(i % 2), PMAC + 48'(i), PIP + 32'(i));
    @(negedge aclk);
    chk("burst_full_ready", 64'(bus.cmd_ready), 64'd0);
    chk("burst_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 5; i++) begin
      set_model(1'(i % 2), PMAC + 48'(i), PIP + 32'(i), LMAC, LIP);
      recv_frame($sformatf("burst%0d", i), 1'b0);
      chk($sformatf("burst%0d_gap", i), 64'(idle_cnt), 64'd0);
    end
    @(negedge aclk);
    chk("burst_tvalid_drop", 64'(bus.tx_axis_tvalid), 64'd0);
    chk("burst_frames", 64'(frames_sent), 64'd8);
    chk("burst_busy_end", 64'(busy), 64'd0);

    // Local MAC changes during beat 2 of the first of two queued frames.
    bus.tx_axis_tready = 1'b0;
    push_cmd(1'b0, PMAC, PIP);
    push_cmd(1'b1, PMAC, PIP + 32'd7);
    set_model(1'b0, PMAC, PIP, LMAC, LIP);
    mac_chg_val = LMAC2;
    mac_chg_en  = 1'b1;
    recv_frame("macold", 1'b0);
    set_model(1'b1, PMAC, PIP + 32'd7, LMAC2, LIP);
    recv_frame("macnew", 1'b0);
    chk("macnew_gap", 64'(idle_cnt), 64'd0);
    @(negedge aclk);
    chk("mac_frames", 64'(frames_sent), 64'd10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
